bist_march_ctrl: RTL and testbench

BIST_MARCH_CTRL -- requirements
Module: bist_march_ctrl

---
 rtl/bist_pkg.sv | 55 +++++
 rtl/bist_addr_gen.sv | 33 +++
 rtl/bist_march_ctrl.sv | 144 ++++++++++++++
 tb/tb_bist_march_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// bist_pkg: shared encodings and March element tables for the SRAM BIST controller
package bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        MODE_MARCH_C = 1'b0,
        MODE_MATS_P  = 1'b1
    } mode_t;

    // Per-element op description; bit 0 of rd/pat is the first op at an address.
    typedef struct packed {
        logic       two_ops;
        logic [1:0] rd;
        logic [1:0] pat;
    } elem_t;

    // March C-: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) down(r0)
    // MATS+   : up(w0) up(r0,w1) down(r1,w0)
    function automatic elem_t get_elem(mode_t m, logic [2:0] idx);
        elem_t e;
        e = '0;
        if (m == MODE_MATS_P) begin
            case (idx)
                3'd1:    e = {1'b1, 2'b01, 2'b10};
                3'd2:    e = {1'b1, 2'b01, 2'b01};
                default: e = {1'b0, 2'b00, 2'b00};
            endcase
        end else begin
            case (idx)
                3'd1:    e = {1'b1, 2'b01, 2'b10};
                3'd2:    e = {1'b1, 2'b01, 2'b01};
                3'd3:    e = {1'b1, 2'b01, 2'b10};
                3'd4:    e = {1'b1, 2'b01, 2'b01};
                3'd5:    e = {1'b0, 2'b01, 2'b00};
                default: e = {1'b0, 2'b00, 2'b00};
            endcase
        end
        return e;
    endfunction

    function automatic logic elem_is_down(mode_t m, logic [2:0] idx);
        return (m == MODE_MATS_P) ? (idx == 3'd2) : (idx >= 3'd3);
    endfunction

    function automatic logic is_last_elem(mode_t m, logic [2:0] idx);
        return idx == ((m == MODE_MATS_P) ? 3'd2 : 3'd5);
    endfunction

endpackage

// File: rtl/bist_addr_gen.sv
// bist_addr_gen: up/down address counter with load-to-start, step and last-address flag
module bist_addr_gen #(
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_load_down,
    input  logic              i_step,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_addr;
    logic              r_down;

    // Load jumps to the first address of the element's direction; step walks toward the far end.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_addr <= '0;
            r_down <= 1'b0;
        end else if (i_load) begin
            r_down <= i_load_down;
            r_addr <= i_load_down ? '1 : '0;
        end else if (i_step) begin
            r_addr <= r_down ? r_addr - 1'b1 : r_addr + 1'b1;
        end
    end

    assign o_addr = r_addr;
    assign o_last = r_down ? (r_addr == '0) : (r_addr == '1);

endmodule

// File: rtl/bist_march_ctrl.sv
// bist_march_ctrl: March C- / MATS+ SRAM BIST controller with pipelined read compare
module bist_march_ctrl
    import bist_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 4,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_mode,
    input  logic [DATA_W-1:0] i_sram_rdata,
    output logic              o_mux_sel,
    output logic              o_cen,
    output logic              o_wen,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [ADDR_W-1:0] o_fail_addr
);

    state_t            r_state, w_next;
    mode_t             r_mode;
    logic [2:0]        r_elem;
    logic              r_op;
    logic              r_rearm;
    logic              r_cmp_valid;
    logic              r_exp_pat;
    logic [ADDR_W-1:0] r_exp_addr;
    logic              r_pass;
    logic [ADDR_W-1:0] r_fail_addr;

    elem_t             w_elem;
    logic              w_rd, w_pat, w_op_last, w_elem_last, w_addr_last;
    logic              w_miss, w_abort, w_issue, w_launch, w_load, w_load_down, w_step;
    logic [ADDR_W-1:0] w_addr;

    assign w_elem      = get_elem(r_mode, r_elem);
    assign w_rd        = w_elem.rd[r_op];
    assign w_pat       = w_elem.pat[r_op];
    assign w_op_last   = !w_elem.two_ops || r_op;
    assign w_elem_last = is_last_elem(r_mode, r_elem);
    assign w_miss      = r_cmp_valid && (i_sram_rdata != {DATA_W{r_exp_pat}});
    assign w_abort     = (STOP_ON_FAIL != 0) && w_miss && (r_state == ST_RUN);
    assign w_issue     = (r_state == ST_RUN) && !w_abort;
    // A relaunch from DONE needs start to have been seen low while in DONE.
    assign w_launch    = i_start && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && r_rearm));
    assign w_load      = w_launch || (w_issue && w_op_last && w_addr_last && !w_elem_last);
    assign w_load_down = w_launch ? elem_is_down(mode_t'(i_mode), 3'd0)
                                  : elem_is_down(r_mode, r_elem + 3'd1);
    assign w_step      = w_issue && w_op_last && !w_addr_last;

    bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_load_down(w_load_down),
        .i_step     (w_step),
        .o_addr     (w_addr),
        .o_last     (w_addr_last)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and SRAM-port decode.
    always_comb begin
        w_next       = r_state;
        o_mux_sel    = 1'b0;
        o_cen        = 1'b0;
        o_wen        = 1'b0;
        o_sram_addr  = '0;
        o_sram_wdata = '0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            ST_IDLE:  w_next = w_launch ? ST_RUN : ST_IDLE;
            ST_RUN: begin
                o_mux_sel    = 1'b1;
                o_busy       = 1'b1;
                o_cen        = w_issue;
                o_wen        = w_issue && !w_rd;
                o_sram_addr  = w_addr;
                o_sram_wdata = {DATA_W{w_pat}};
                if (w_abort || (w_op_last && w_addr_last && w_elem_last)) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                o_busy = 1'b1;
                w_next = ST_DONE;
            end
            ST_DONE: begin
                o_done = 1'b1;
                w_next = w_launch ? ST_RUN : ST_DONE;
            end
            default:  w_next = ST_IDLE;
        endcase
    end

    // Sequencing through elements/ops, registering read expectations and recording the first miscompare.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_mode      <= MODE_MARCH_C;
            r_elem      <= '0;
            r_op        <= 1'b0;
            r_rearm     <= 1'b0;
            r_cmp_valid <= 1'b0;
            r_exp_pat   <= 1'b0;
            r_exp_addr  <= '0;
            r_pass      <= 1'b1;
            r_fail_addr <= '0;
        end else begin
            r_rearm     <= (r_state == ST_DONE) && (r_rearm || !i_start);
            r_cmp_valid <= w_issue && w_rd;
            r_exp_pat   <= w_pat;
            r_exp_addr  <= w_addr;
            if (w_launch) begin
                r_mode      <= mode_t'(i_mode);
                r_elem      <= '0;
                r_op        <= 1'b0;
                r_pass      <= 1'b1;
                r_fail_addr <= '0;
            end else begin
                if (w_issue) begin
                    r_op <= !w_op_last;
                    if (w_op_last && w_addr_last && !w_elem_last) r_elem <= r_elem + 3'd1;
                end
                if (w_miss && r_pass) begin
                    r_pass      <= 1'b0;
                    r_fail_addr <= r_exp_addr;
                end
            end
        end
    end

    assign o_pass      = r_pass;
    assign o_fail_addr = r_fail_addr;

endmodule

// File: tb/tb_bist_march_ctrl.sv
// tb_bist_march_ctrl: table-driven and randomized checks of both STOP_ON_FAIL variants against an algorithm-level model
module tb_bist_march_ctrl;

    localparam int AW = 2;
    localparam int DW = 4;
    localparam int N  = 4;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, mode = 1'b0;
    logic cen [2], wen [2], mux [2], busy [2], done [2], pass [2];
    logic [AW-1:0] addr [2], fa [2];
    logic [DW-1:0] wd [2];

    logic          f_en   = 1'b0;
    logic [AW-1:0] f_addr = '0;
    logic [DW-1:0] f_val  = '0;

    int n_pass = 0, n_tot = 0;

    int e_addr [$];
    bit e_wr   [$];
    bit e_dat  [$];
    int m_k;
    int x_ops [2], x_done [2], x_pass, x_fa;
    int obs_done [2], obs_pass [2], obs_fa [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [DW-1:0] mem [N];
        logic [DW-1:0] rdat;
        bist_march_ctrl #(.ADDR_W(AW), .DATA_W(DW), .STOP_ON_FAIL(g)) u_dut (
            .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_sram_rdata(rdat),
            .o_mux_sel(mux[g]), .o_cen(cen[g]), .o_wen(wen[g]), .o_sram_addr(addr[g]),
            .o_sram_wdata(wd[g]), .o_busy(busy[g]), .o_done(done[g]), .o_pass(pass[g]),
            .o_fail_addr(fa[g])
        );
        always @(posedge clk) begin
            if (cen[g]) begin
                if (wen[g]) mem[addr[g]] <= wd[g];
                else        rdat <= (f_en && addr[g] == f_addr) ? f_val : mem[addr[g]];
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_tot++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    function automatic int alg_len(input bit m);
        return m ? 3 : 6;
    endfunction

    function automatic string alg_elem(input bit m, input int i);
        string mc [6] = '{"Uw0", "Ur0w1", "Ur1w0", "Dr0w1", "Dr1w0", "Dr0"};
        string mt [3] = '{"Uw0", "Ur0w1", "Dr1w0"};
        return m ? mt[i] : mc[i];
    endfunction

    task automatic build_model(input bit m);
        logic [DW-1:0] mv [N];
        logic [DW-1:0] pat, got;
        string s;
        int n;
        e_addr.delete(); e_wr.delete(); e_dat.delete();
        m_k = -1;
        for (int a = 0; a < N; a++) mv[a] = '0;
        for (int i = 0; i < alg_len(m); i++) begin
            s = alg_elem(m, i);
            for (int a = 0; a < N; a++)
                for (int j = 1; j < s.len(); j += 2) begin
                    e_addr.push_back(s[0] == "D" ? N - 1 - a : a);
                    e_wr.push_back(s[j] == "w");
                    e_dat.push_back(s[j+1] == "1");
                end
        end
        n = e_addr.size();
        for (int k = 0; k < n; k++) begin
            pat = e_dat[k] ? '1 : '0;
            got = (f_en && e_addr[k] == int'(f_addr)) ? f_val : mv[e_addr[k]];
            if (e_wr[k]) mv[e_addr[k]] = pat;
            else if (m_k < 0 && got != pat) m_k = k;
        end
        x_pass = (m_k < 0);
        x_fa   = (m_k < 0) ? 0 : e_addr[m_k];
        x_ops[0] = n; x_done[0] = n + 1;
        x_ops[1] = (m_k >= 0 && m_k < n - 1) ? m_k + 1 : n;
        x_done[1] = (m_k >= 0 && m_k < n - 1) ? m_k + 3 : n + 1;
    endtask

    task automatic run_test(input bit m, input bit hold);
        int idx [2] = '{0, 0};
        int dc  [2] = '{-1, -1};
        bit bad [2] = '{0, 0};
        build_model(m);
        @(negedge clk); mode = m; start = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 200 && (dc[0] < 0 || dc[1] < 0); c++) begin
            @(negedge clk);
            if (c == 0 && !hold) start = 1'b0;
            for (int d = 0; d < 2; d++) if (dc[d] < 0) begin
                if (cen[d]) begin
                    if (idx[d] >= x_ops[d] || int'(addr[d]) != e_addr[idx[d]] || wen[d] != e_wr[idx[d]]
                        || wd[d] != {DW{e_dat[idx[d]]}} || !mux[d]) bad[d] = 1'b1;
                    idx[d]++;
                end
                if (done[d]) dc[d] = c;
            end
        end
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("sof%0d_op_count", d), idx[d], x_ops[d]);
            chk($sformatf("sof%0d_op_seq_bad", d), int'(bad[d]), 0);
            chk($sformatf("sof%0d_done_cycle", d), dc[d], x_done[d]);
            chk($sformatf("sof%0d_pass", d), int'(pass[d]), x_pass);
            chk($sformatf("sof%0d_fail_addr", d), int'(fa[d]), x_fa);
            obs_done[d] = dc[d]; obs_pass[d] = int'(pass[d]); obs_fa[d] = int'(fa[d]);
        end
    endtask

    task automatic chk_idle(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s%0d_mux", tag, d), int'(mux[d]), 0);
            chk($sformatf("%s%0d_cen", tag, d), int'(cen[d]), 0);
            chk($sformatf("%s%0d_wen", tag, d), int'(wen[d]), 0);
            chk($sformatf("%s%0d_addr", tag, d), int'(addr[d]), 0);
            chk($sformatf("%s%0d_wdata", tag, d), int'(wd[d]), 0);
            chk($sformatf("%s%0d_busy", tag, d), int'(busy[d]), 0);
            chk($sformatf("%s%0d_done", tag, d), int'(done[d]), 0);
            chk($sformatf("%s%0d_pass", tag, d), int'(pass[d]), 1);
            chk($sformatf("%s%0d_fail_addr", tag, d), int'(fa[d]), 0);
        end
    endtask

    typedef struct {
        bit m; bit fe; int fadr; int fv;
        int pass0, fa0, done0, pass1, fa1, done1;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl [5];
        tbl[0] = '{0, 0, 0, 0,   1, 0, 41,  1, 0, 41};
        tbl[1] = '{1, 0, 0, 0,   1, 0, 21,  1, 0, 21};
        tbl[2] = '{0, 1, 2, 5,   0, 2, 41,  0, 2, 11};
        tbl[3] = '{0, 1, 1, 0,   0, 1, 41,  0, 1, 17};
        tbl[4] = '{1, 1, 3, 15,  0, 3, 21,  0, 3, 13};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            f_en = tbl[i].fe; f_addr = AW'(tbl[i].fadr); f_val = DW'(tbl[i].fv);
            run_test(tbl[i].m, 1'b0);
            chk($sformatf("tbl%0d_done0", i), obs_done[0], tbl[i].done0);
            chk($sformatf("tbl%0d_pass0", i), obs_pass[0], tbl[i].pass0);
            chk($sformatf("tbl%0d_fa0", i), obs_fa[0], tbl[i].fa0);
            chk($sformatf("tbl%0d_done1", i), obs_done[1], tbl[i].done1);
            chk($sformatf("tbl%0d_pass1", i), obs_pass[1], tbl[i].pass1);
            chk($sformatf("tbl%0d_fa1", i), obs_fa[1], tbl[i].fa1);
        end

        // reset in the middle of a failing March C- run
        f_en = 1'b1; f_addr = 2'd0; f_val = 4'hF;
        @(negedge clk); mode = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_idle("midrst");
        rst = 1'b1; f_en = 1'b0;
        run_test(1'b0, 1'b0);

        // start held high in DONE must not relaunch; a low-then-high start must
        f_en = 1'b1; f_addr = 2'd2; f_val = 4'h5;
        run_test(1'b0, 1'b1);
        repeat (6) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("hold%0d_done", d), int'(done[d]), 1);
            chk($sformatf("hold%0d_busy", d), int'(busy[d]), 0);
            chk($sformatf("hold%0d_cen", d), int'(cen[d]), 0);
            chk($sformatf("hold%0d_pass", d), int'(pass[d]), 0);
        end
        f_en = 1'b0;
        start = 1'b0;
        @(negedge clk);
        run_test(1'b0, 1'b0);
        chk("relaunch_pass0", obs_pass[0], 1);
        chk("relaunch_pass1", obs_pass[1], 1);

        for (int i = 0; i < 10; i++) begin
            f_en   = 1'($urandom_range(0, 1));
            f_addr = AW'($urandom_range(0, N - 1));
            f_val  = DW'($urandom_range(0, 15));
            run_test(1'($urandom_range(0, 1)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
